ysyx_22050019_rd_arbiter: RTL and testbench
===========================================

Name: ysyx_22050019_rd_arbiter

Overview:
- Two-master, one-slave read-channel arbiter between the L1 caches and the memory-side AXI read port.
- Master 0 is the icache miss port; master 1 is the dcache `cache_ar_*` / `cache_r_*` port.
- Round-robin grant, one outstanding single-beat read at a time, registered slave AR channel, combinational R return path.
- dcache write channels (AW/W/B) bypass this block and go straight to the memory port.

Parameters:
- ADDR_WIDTH, 32, read address width.
- DATA_WIDTH, 64, read data width; one beat per transaction.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- m0_ar_valid  in  1  icache read request.
- m0_ar_ready  out  1  icache request accepted.
- m0_ar_addr  in  ADDR_WIDTH  icache line address.
- m0_r_valid  out  1  icache read data valid.
- m0_r_ready  in  1  icache ready for data.
- m0_r_data  out  DATA_WIDTH  icache read data.
- m0_r_resp  out  2  icache read response.
- m1_ar_valid  in  1  dcache read request.
- m1_ar_ready  out  1  dcache request accepted.
- m1_ar_addr  in  ADDR_WIDTH  dcache address.
- m1_r_valid  out  1  dcache read data valid.
- m1_r_ready  in  1  dcache ready for data.
- m1_r_data  out  DATA_WIDTH  dcache read data.
- m1_r_resp  out  2  dcache read response.
- s_ar_valid  out  1  slave read request.
- s_ar_ready  in  1  slave accepts request.
- s_ar_addr  out  ADDR_WIDTH  slave address.
- s_r_valid  in  1  slave data valid.
- s_r_ready  out  1  arbiter ready for data.
- s_r_data  in  DATA_WIDTH  slave data.
- s_r_resp  in  2  slave response.
- rd_err_o  out  1  sticky flag: some read returned a nonzero resp.

Behaviour:
- FSM states: IDLE, AR, R. Registers:
  - state
  - grant (1 bit)
  - last_grant (1 bit)
  - addr_q
  - s_ar_valid
  - rd_err_o
- Reset (async, takes effect immediately, including mid-transaction): state=IDLE, s_ar_valid=0, s_ar_addr=0, last_grant=1 (master 0 wins first), rd_err_o=0.
  - All combinational outputs then evaluate to 0.
  - An in-flight slave beat is dropped; masters are reset by the same rst.
- IDLE:
  - Grant selection (combinational): if only one master's ar_valid is high, that master; if both, the master != last_grant.
  - mX_ar_ready = (state==IDLE) && sel==X. This is combinational from ar_valid and is never high for both masters.
  - On an mX AR handshake in cycle N: grant<=X, s_ar_addr<=mX_ar_addr, s_ar_valid<=1, state<=AR. s_ar_valid is first visible in cycle N+1.
  - No request: stay IDLE, all readies 0.
- AR:
  - Hold s_ar_valid and s_ar_addr stable until s_ar_ready.
  - On handshake: s_ar_valid<=0, state<=R.
- R, all combinational:
  - s_r_ready = m[grant]_r_ready.
  - m[grant]_r_valid = s_r_valid.
  - m[grant]_r_data = s_r_data.
  - m[grant]_r_resp = s_r_resp.
  - The non-granted master sees r_valid=0, r_data=0, r_resp=0.
- On the s_r handshake:
  - state<=IDLE, last_grant<=grant.
  - If s_r_resp != 0, rd_err_o<=1. rd_err_o stays set until reset.
- Minimum transaction: 3 cycles (IDLE handshake, AR handshake, R handshake). Back-to-back grants have no idle bubble beyond the IDLE cycle itself.
- Simultaneous requests in IDLE: exactly one grant. The loser keeps ar_valid high and is granted at the next IDLE.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1.
- A master's ar_valid dropping before its handshake is tolerated. Nothing is latched, and selection re-evaluates every IDLE cycle.
- Requests arriving while in AR or R are not accepted: ar_ready stays 0.
- s_r_valid in IDLE or AR is a slave protocol error: it is ignored and s_r_ready=0.
- Address is forwarded unmodified; no width conversion.

Test Plan:
1. Reset, then m0 requests 0x8000_0000; slave ar_ready=1; r returns 0x1122334455667788 with resp 0 → m0_ar_ready=1 in cycle N, s_ar_valid=1 with addr 0x80000000 in N+1, m0 sees the data; m1_r_valid stays 0; rd_err_o=0.
2. m0 and m1 both request continuously from reset (addrs 0x100 and 0x200), slave zero-wait → s_ar_addr sequence 0x100, 0x200, 0x100, 0x200; each m_r_valid goes only to its owner.
3. Slave holds s_ar_ready=0 for 5 cycles → s_ar_valid and s_ar_addr are stable for all 5 cycles; m1 requests during this time get no ar_ready until the m0 R handshake completes.
4. R backpressure: s_r_valid=1 while m1_r_ready=0 for 3 cycles → s_r_ready=0 for those cycles; data 0xDEAD_BEEF_0000_0001 is delivered to m1 on the cycle m1_r_ready rises; state then returns to IDLE.
5. Slave returns resp=2'b10 on an m1 read → m1_r_resp=2; rd_err_o=1 from the next cycle and stays 1 through subsequent resp=0 reads.
6. Assert rst asynchronously (between clock edges) while in R with s_r_valid=1 → s_ar_valid, all ready/valid outputs and rd_err_o go to 0 immediately; after release, the first contended grant goes to m0.

Source files
------------

// File: rtl/ysyx_22050019_rd_arbiter.sv
// Two-master round-robin read arbiter in front of the memory-side AXI AR/R port.
// One outstanding single-beat read; registered slave AR, combinational R return.
module ysyx_22050019_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_ar_valid,
  output logic                  m0_ar_ready,
  input  logic [ADDR_WIDTH-1:0] m0_ar_addr,
  output logic                  m0_r_valid,
  input  logic                  m0_r_ready,
  output logic [DATA_WIDTH-1:0] m0_r_data,
  output logic [1:0]            m0_r_resp,
  input  logic                  m1_ar_valid,
  output logic                  m1_ar_ready,
  input  logic [ADDR_WIDTH-1:0] m1_ar_addr,
  output logic                  m1_r_valid,
  input  logic                  m1_r_ready,
  output logic [DATA_WIDTH-1:0] m1_r_data,
  output logic [1:0]            m1_r_resp,
  output logic                  s_ar_valid,
  input  logic                  s_ar_ready,
  output logic [ADDR_WIDTH-1:0] s_ar_addr,
  input  logic                  s_r_valid,
  output logic                  s_r_ready,
  input  logic [DATA_WIDTH-1:0] s_r_data,
  input  logic [1:0]            s_r_resp,
  output logic                  rd_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_grant;
  logic                  r_last_grant;
  logic                  r_s_ar_valid;
  logic                  r_rd_err;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic w_idle;
  logic w_any;
  logic w_sel;
  logic w_ar_hs;
  logic w_s_r_ready;
  logic w_s_r_hs;

  assign w_idle  = (r_state == S_IDLE);
  assign w_any   = m0_ar_valid | m1_ar_valid;
  assign w_ar_hs = w_idle & w_any & ~rst;

  // Pick a master: the lone requester, or the one not served last time.
  always_comb begin
    w_sel = 1'b0;
    if (m0_ar_valid && m1_ar_valid)
      w_sel = ~r_last_grant;
    else if (m1_ar_valid)
      w_sel = 1'b1;
  end

  assign m0_ar_ready = w_ar_hs & ~w_sel;
  assign m1_ar_ready = w_ar_hs &  w_sel;

  // Next-state logic for the IDLE -> AR -> R transaction sequence.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_ar_hs) w_state_nxt = S_AR;
      S_AR:   if (s_ar_ready) w_state_nxt = S_R;
      S_R:    if (w_s_r_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // R channel routed to the granted master only while in R.
  always_comb begin
    w_s_r_ready = 1'b0;
    m0_r_valid  = 1'b0;
    m0_r_data   = '0;
    m0_r_resp   = 2'b00;
    m1_r_valid  = 1'b0;
    m1_r_data   = '0;
    m1_r_resp   = 2'b00;
    if (r_state == S_R) begin
      if (r_grant) begin
        w_s_r_ready = m1_r_ready;
        m1_r_valid  = s_r_valid;
        m1_r_data   = s_r_data;
        m1_r_resp   = s_r_resp;
      end else begin
        w_s_r_ready = m0_r_ready;
        m0_r_valid  = s_r_valid;
        m0_r_data   = s_r_data;
        m0_r_resp   = s_r_resp;
      end
    end
  end

  assign w_s_r_hs  = (r_state == S_R) & s_r_valid & w_s_r_ready;
  assign s_r_ready = w_s_r_ready;

  // Grant, slave AR register, round-robin history and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_s_ar_valid <= 1'b0;
      r_addr       <= '0;
      r_rd_err     <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_grant      <= w_sel;
        r_addr       <= w_sel ? m1_ar_addr : m0_ar_addr;
        r_s_ar_valid <= 1'b1;
      end
      if (r_state == S_AR && s_ar_ready)
        r_s_ar_valid <= 1'b0;
      if (w_s_r_hs) begin
        r_last_grant <= r_grant;
        if (s_r_resp != 2'b00)
          r_rd_err <= 1'b1;
      end
    end
  end

  assign s_ar_valid = r_s_ar_valid;
  assign s_ar_addr  = r_addr;
  assign rd_err_o   = r_rd_err;

endmodule

// File: tb/tb_ysyx_22050019_rd_arbiter.sv
// Self-checking bench for the two-master read arbiter.
// Expected AR addresses and R beats are queued at stimulus time, checked on handshakes.
module tb_ysyx_22050019_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] d;
    logic [1:0]    r;
  } rexp_t;

  logic          clk;
  logic          rst;
  logic          m0_ar_valid;
  logic          m0_ar_ready;
  logic [AW-1:0] m0_ar_addr;
  logic          m0_r_valid;
  logic          m0_r_ready;
  logic [DW-1:0] m0_r_data;
  logic [1:0]    m0_r_resp;
  logic          m1_ar_valid;
  logic          m1_ar_ready;
  logic [AW-1:0] m1_ar_addr;
  logic          m1_r_valid;
  logic          m1_r_ready;
  logic [DW-1:0] m1_r_data;
  logic [1:0]    m1_r_resp;
  logic          s_ar_valid;
  logic          s_ar_ready;
  logic [AW-1:0] s_ar_addr;
  logic          s_r_valid;
  logic          s_r_ready;
  logic [DW-1:0] s_r_data;
  logic [1:0]    s_r_resp;
  logic          rd_err_o;

  int n_chk = 0;
  int n_err = 0;

  logic [AW-1:0] q_ar[$];
  rexp_t         q_r[$];

  logic          pend;
  logic [AW-1:0] paddr;
  logic [1:0]    slv_resp;

  ysyx_22050019_rd_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .m0_ar_valid(m0_ar_valid),
    .m0_ar_ready(m0_ar_ready),
    .m0_ar_addr(m0_ar_addr),
    .m0_r_valid(m0_r_valid),
    .m0_r_ready(m0_r_ready),
    .m0_r_data(m0_r_data),
    .m0_r_resp(m0_r_resp),
    .m1_ar_valid(m1_ar_valid),
    .m1_ar_ready(m1_ar_ready),
    .m1_ar_addr(m1_ar_addr),
    .m1_r_valid(m1_r_valid),
    .m1_r_ready(m1_r_ready),
    .m1_r_data(m1_r_data),
    .m1_r_resp(m1_r_resp),
    .s_ar_valid(s_ar_valid),
    .s_ar_ready(s_ar_ready),
    .s_ar_addr(s_ar_addr),
    .s_r_valid(s_r_valid),
    .s_r_ready(s_r_ready),
    .s_r_data(s_r_data),
    .s_r_resp(s_r_resp),
    .rd_err_o(rd_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic slave_idle();
    s_r_valid = 1'b0;
    s_r_data  = '0;
    s_r_resp  = 2'b00;
  endtask

  // Zero-wait slave; masters optionally drop ar_valid once accepted.
  task automatic run_auto(input int n, input bit hold, input int budget);
    int  done;
    int  cyc;
    bit  d0;
    bit  d1;
    done = 0;
    cyc  = 0;
    pend = 1'b0;
    s_ar_ready = 1'b1;
    while (done < n && cyc < budget) begin
      mid();
      d0 = m0_ar_valid & m0_ar_ready;
      d1 = m1_ar_valid & m1_ar_ready;
      if (s_r_valid && s_r_ready) begin
        pend = 1'b0;
        done++;
      end
      if (s_ar_valid && s_ar_ready) begin
        pend  = 1'b1;
        paddr = s_ar_addr;
      end
      cyc++;
      if (done < n) begin
        step();
        if (!hold && d0) m0_ar_valid = 1'b0;
        if (!hold && d1) m1_ar_valid = 1'b0;
        s_r_valid = pend;
        s_r_data  = pend ? dat(paddr) : '0;
        s_r_resp  = pend ? slv_resp : 2'b00;
      end
    end
    chk("auto_done", 64'(done), 64'(n));
  endtask

  // Scoreboard side: pop expectations on slave AR and master R handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_ar_valid && m1_ar_valid)
        chk("ar_ready_excl", 64'(m0_ar_ready & m1_ar_ready), 64'(0));
      if (s_ar_valid && s_ar_ready) begin
        chk("ar_q", 64'(q_ar.size() != 0), 64'(1));
        if (q_ar.size() != 0)
          chk("s_ar_addr", 64'(s_ar_addr), 64'(q_ar.pop_front()));
      end
      if (m0_r_valid && m0_r_ready) begin
        chk("r_q", 64'(q_r.size() != 0), 64'(1));
        if (q_r.size() != 0) begin
          rexp_t e;
          e = q_r.pop_front();
          chk("r_owner", 64'(0), 64'(e.m));
          chk("m0_r_data", m0_r_data, e.d);
          chk("m0_r_resp", 64'(m0_r_resp), 64'(e.r));
          chk("m1_r_valid_off", 64'(m1_r_valid), 64'(0));
          chk("m1_r_data_off", m1_r_data, 64'(0));
        end
      end
      if (m1_r_valid && m1_r_ready) begin
        chk("r_q", 64'(q_r.size() != 0), 64'(1));
        if (q_r.size() != 0) begin
          rexp_t e;
          e = q_r.pop_front();
          chk("r_owner", 64'(1), 64'(e.m));
          chk("m1_r_data", m1_r_data, e.d);
          chk("m1_r_resp", 64'(m1_r_resp), 64'(e.r));
          chk("m0_r_valid_off", 64'(m0_r_valid), 64'(0));
          chk("m0_r_data_off", m0_r_data, 64'(0));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_ar_valid = 1'b0;
    m0_ar_addr  = '0;
    m0_r_ready  = 1'b0;
    m1_ar_valid = 1'b0;
    m1_ar_addr  = '0;
    m1_r_ready  = 1'b0;
    s_ar_ready  = 1'b0;
    slv_resp    = 2'b00;
    pend        = 1'b0;
    paddr       = '0;
    slave_idle();
    repeat (3) @(posedge clk);
    mid();
    chk("rst_s_ar_valid", 64'(s_ar_valid), 64'(0));
    chk("rst_s_ar_addr", 64'(s_ar_addr), 64'(0));
    chk("rst_rd_err", 64'(rd_err_o), 64'(0));
    chk("rst_s_r_ready", 64'(s_r_ready), 64'(0));
    step();
    rst = 1'b0;

    // single m0 read
    step();
    m0_ar_valid = 1'b1;
    m0_ar_addr  = 32'h8000_0000;
    s_ar_ready  = 1'b1;
    q_ar.push_back(32'h8000_0000);
    mid();
    chk("t1_m0_ar_ready", 64'(m0_ar_ready), 64'(1));
    chk("t1_m1_ar_ready", 64'(m1_ar_ready), 64'(0));
    chk("t1_s_ar_valid_n", 64'(s_ar_valid), 64'(0));
    step();
    m0_ar_valid = 1'b0;
    mid();
    chk("t1_s_ar_valid_n1", 64'(s_ar_valid), 64'(1));
    chk("t1_s_ar_addr", 64'(s_ar_addr), 64'(32'h8000_0000));
    step();
    s_r_valid  = 1'b1;
    s_r_data   = 64'h1122_3344_5566_7788;
    s_r_resp   = 2'b00;
    m0_r_ready = 1'b1;
    q_r.push_back('{m: 1'b0, d: 64'h1122_3344_5566_7788, r: 2'b00});
    mid();
    chk("t1_m1_r_valid", 64'(m1_r_valid), 64'(0));
    chk("t1_s_r_ready", 64'(s_r_ready), 64'(1));
    step();
    slave_idle();
    mid();
    chk("t1_rd_err", 64'(rd_err_o), 64'(0));

    // continuous contention from reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m1_r_ready  = 1'b1;
    m0_ar_valid = 1'b1;
    m0_ar_addr  = 32'h100;
    m1_ar_valid = 1'b1;
    m1_ar_addr  = 32'h200;
    for (int i = 0; i < 2; i++) begin
      q_ar.push_back(32'h100);
      q_r.push_back('{m: 1'b0, d: dat(32'h100), r: 2'b00});
      q_ar.push_back(32'h200);
      q_r.push_back('{m: 1'b1, d: dat(32'h200), r: 2'b00});
    end
    run_auto(4, 1'b1, 40);
    step();
    m0_ar_valid = 1'b0;
    m1_ar_valid = 1'b0;
    slave_idle();

    // slave AR stall, m1 blocked meanwhile
    step();
    m0_ar_valid = 1'b1;
    m0_ar_addr  = 32'h300;
    s_ar_ready  = 1'b0;
    q_ar.push_back(32'h300);
    mid();
    chk("t3_m0_ar_ready", 64'(m0_ar_ready), 64'(1));
    step();
    m0_ar_valid = 1'b0;
    m1_ar_valid = 1'b1;
    m1_ar_addr  = 32'h400;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t3_s_ar_valid", 64'(s_ar_valid), 64'(1));
      chk("t3_s_ar_addr", 64'(s_ar_addr), 64'(32'h300));
      chk("t3_m1_blocked", 64'(m1_ar_ready), 64'(0));
      step();
      if (i == 4) s_ar_ready = 1'b1;
    end
    mid();
    chk("t3_m1_blocked_ar", 64'(m1_ar_ready), 64'(0));
    step();
    s_ar_ready = 1'b0;
    s_r_valid  = 1'b1;
    s_r_data   = dat(32'h300);
    q_r.push_back('{m: 1'b0, d: dat(32'h300), r: 2'b00});
    mid();
    chk("t3_m1_blocked_r", 64'(m1_ar_ready), 64'(0));
    step();
    slave_idle();
    q_ar.push_back(32'h400);
    mid();
    chk("t3_m1_granted", 64'(m1_ar_ready), 64'(1));

    // R backpressure on m1
    step();
    m1_ar_valid = 1'b0;
    s_ar_ready  = 1'b1;
    mid();
    step();
    s_ar_ready = 1'b0;
    s_r_valid  = 1'b1;
    s_r_data   = 64'hDEAD_BEEF_0000_0001;
    m1_r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t4_s_r_ready", 64'(s_r_ready), 64'(0));
      chk("t4_m1_r_valid", 64'(m1_r_valid), 64'(1));
      step();
      if (i == 2) begin
        m1_r_ready = 1'b1;
        q_r.push_back('{m: 1'b1, d: 64'hDEAD_BEEF_0000_0001, r: 2'b00});
      end
    end
    mid();
    chk("t4_s_r_ready_up", 64'(s_r_ready), 64'(1));
    step();
    slave_idle();
    m0_ar_valid = 1'b1;
    m0_ar_addr  = 32'h500;
    q_ar.push_back(32'h500);
    mid();
    chk("t4_back_idle", 64'(m0_ar_ready), 64'(1));
    step();
    m0_ar_valid = 1'b0;
    q_r.push_back('{m: 1'b0, d: dat(32'h500), r: 2'b00});
    run_auto(1, 1'b0, 20);
    step();
    slave_idle();

    // error response sticks
    m1_ar_valid = 1'b1;
    m1_ar_addr  = 32'h600;
    slv_resp    = 2'b10;
    q_ar.push_back(32'h600);
    q_r.push_back('{m: 1'b1, d: dat(32'h600), r: 2'b10});
    run_auto(1, 1'b0, 20);
    chk("t5_err_same_cycle", 64'(rd_err_o), 64'(0));
    step();
    slave_idle();
    mid();
    chk("t5_err_set", 64'(rd_err_o), 64'(1));
    step();
    slv_resp    = 2'b00;
    m0_ar_valid = 1'b1;
    m0_ar_addr  = 32'h700;
    m1_ar_valid = 1'b1;
    m1_ar_addr  = 32'h800;
    q_ar.push_back(32'h700);
    q_r.push_back('{m: 1'b0, d: dat(32'h700), r: 2'b00});
    q_ar.push_back(32'h800);
    q_r.push_back('{m: 1'b1, d: dat(32'h800), r: 2'b00});
    run_auto(2, 1'b0, 30);
    step();
    slave_idle();
    mid();
    chk("t5_err_sticky", 64'(rd_err_o), 64'(1));

    // async reset mid-beat
    step();
    m0_ar_valid = 1'b1;
    m0_ar_addr  = 32'h900;
    s_ar_ready  = 1'b1;
    q_ar.push_back(32'h900);
    mid();
    step();
    m0_ar_valid = 1'b0;
    mid();
    step();
    s_r_valid  = 1'b1;
    s_r_data   = dat(32'h900);
    m0_r_ready = 1'b0;
    mid();
    chk("t6_pre_m0_r_valid", 64'(m0_r_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_s_ar_valid", 64'(s_ar_valid), 64'(0));
    chk("t6_m0_r_valid", 64'(m0_r_valid), 64'(0));
    chk("t6_m1_r_valid", 64'(m1_r_valid), 64'(0));
    chk("t6_s_r_ready", 64'(s_r_ready), 64'(0));
    chk("t6_m0_ar_ready", 64'(m0_ar_ready), 64'(0));
    chk("t6_m1_ar_ready", 64'(m1_ar_ready), 64'(0));
    chk("t6_rd_err", 64'(rd_err_o), 64'(0));
    step();
    slave_idle();
    m0_r_ready = 1'b1;
    step();
    rst = 1'b0;
    m0_ar_valid = 1'b1;
    m0_ar_addr  = 32'hA00;
    m1_ar_valid = 1'b1;
    m1_ar_addr  = 32'hB00;
    q_ar.push_back(32'hA00);
    q_r.push_back('{m: 1'b0, d: dat(32'hA00), r: 2'b00});
    q_ar.push_back(32'hB00);
    q_r.push_back('{m: 1'b1, d: dat(32'hB00), r: 2'b00});
    mid();
    chk("t6_first_m0", 64'(m0_ar_ready), 64'(1));
    chk("t6_first_not_m1", 64'(m1_ar_ready), 64'(0));
    step();
    m0_ar_valid = 1'b0;
    run_auto(2, 1'b0, 30);
    step();
    slave_idle();
    m1_ar_valid = 1'b0;
    mid();

    chk("ar_q_left", 64'(q_ar.size()), 64'(0));
    chk("r_q_left", 64'(q_r.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
